prv32_alu_sequencer: RTL and testbench

PRV32_ALU_SEQUENCER -- requirements
Module: prv32_alu_sequencer

---
 rtl/prv32_pkg.sv | 106 ++++++++++
 rtl/prv32_alu_sequencer_if.sv | 42 ++++
 rtl/prv32_serial_shifter.sv | 47 ++++
 rtl/prv32_alu_sequencer.sv | 150 +++++++++++++++
 tb/tb_prv32_alu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prv32_pkg.sv
// Shared encodings for the PRV32 ALU sequencer: ALU function codes, FSM states,
// funct3 constants and the small decode helpers used by the sequencer.
package prv32_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned F3_W    = 3;

  typedef enum logic [3:0] {
    ALUFN_ADD  = 4'b0000,
    ALUFN_SUB  = 4'b0001,
    ALUFN_PASS = 4'b0011,
    ALUFN_OR   = 4'b0100,
    ALUFN_AND  = 4'b0101,
    ALUFN_XOR  = 4'b0111,
    ALUFN_SRL  = 4'b1000,
    ALUFN_SLL  = 4'b1001,
    ALUFN_SRA  = 4'b1010,
    ALUFN_SLT  = 4'b1101,
    ALUFN_SLTU = 4'b1111
  } alufn_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_e;

  // ALU-op funct3
  localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
  localparam logic [F3_W-1:0] F3_SR   = 3'b101;
  localparam logic [F3_W-1:0] F3_OR   = 3'b110;
  localparam logic [F3_W-1:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  // Control fields of an accepted operation kept alive through ISSUE
  typedef struct packed {
    logic [F3_W-1:0] funct3;
    logic            is_branch;
  } op_ctl_t;

  function automatic alufn_e decode_alufn(input logic [F3_W-1:0] funct3,
                                          input logic            funct7_5,
                                          input logic            is_imm,
                                          input logic            is_branch);
    alufn_e f;
    f = ALUFN_ADD;
    if (is_branch) begin
      f = ALUFN_SUB;
    end else begin
      case (funct3)
        F3_ADD:  f = (!is_imm && funct7_5) ? ALUFN_SUB : ALUFN_ADD;
        F3_SLL:  f = ALUFN_SLL;
        F3_SLT:  f = ALUFN_SLT;
        F3_SLTU: f = ALUFN_SLTU;
        F3_XOR:  f = ALUFN_XOR;
        F3_SR:   f = funct7_5 ? ALUFN_SRA : ALUFN_SRL;
        F3_OR:   f = ALUFN_OR;
        F3_AND:  f = ALUFN_AND;
        default: f = ALUFN_ADD;
      endcase
    end
    return f;
  endfunction

  // Branch outcome from the flags of rs1 - rs2
  function automatic logic branch_cond(input logic [F3_W-1:0] funct3,
                                       input logic cf, input logic zf,
                                       input logic vf, input logic sf);
    logic t;
    t = 1'b0;
    case (funct3)
      F3_BEQ:  t = zf;
      F3_BNE:  t = !zf;
      F3_BLT:  t = (sf != vf);
      F3_BGE:  t = (sf == vf);
      F3_BLTU: t = !cf;
      F3_BGEU: t = cf;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic is_shift_op(input logic [F3_W-1:0] funct3);
    return (funct3 == F3_SLL) || (funct3 == F3_SR);
  endfunction

endpackage

// File: rtl/prv32_alu_sequencer_if.sv
// Operation/result handshake plus the ALU-side operand/flag bus of the sequencer.
// master = requester and ALU environment, slave = sequencer.
interface prv32_alu_sequencer_if;
  import prv32_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [F3_W-1:0]   funct3;
  logic              funct7_5;
  logic              is_imm;
  logic              is_branch;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic [XLEN-1:0]   imm;

  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [3:0]        alufn;
  logic [XLEN-1:0]   alu_r;
  logic              alu_cf;
  logic              alu_zf;
  logic              alu_vf;
  logic              alu_sf;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;
  logic              branch_taken;

  modport master (
    output in_valid, funct3, funct7_5, is_imm, is_branch, rs1_val, rs2_val, imm,
    output alu_r, alu_cf, alu_zf, alu_vf, alu_sf, out_ready,
    input  in_ready, alu_a, alu_b, alufn, out_valid, result, branch_taken
  );

  modport slave (
    input  in_valid, funct3, funct7_5, is_imm, is_branch, rs1_val, rs2_val, imm,
    input  alu_r, alu_cf, alu_zf, alu_vf, alu_sf, out_ready,
    output in_ready, alu_a, alu_b, alufn, out_valid, result, branch_taken
  );

endinterface

// File: rtl/prv32_serial_shifter.sv
// One-bit-per-cycle shifter: load data/shamt/kind, then shifts once per cycle
// until the count reaches zero. Used only when SERIAL_SHIFT_EN is defined.
module prv32_serial_shifter
  import prv32_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  shift_kind_e        i_kind,
  input  logic [XLEN-1:0]    i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [XLEN-1:0]    o_next_c,
  output logic               o_last_c
);

  logic [XLEN-1:0]    r_data;
  logic [SHAMT_W-1:0] r_cnt;
  shift_kind_e        r_kind;

  // Value after the step taken on the coming edge
  always_comb begin
    o_next_c = {1'b0, r_data[XLEN-1:1]};
    case (r_kind)
      SH_SLL:  o_next_c = {r_data[XLEN-2:0], 1'b0};
      SH_SRA:  o_next_c = {r_data[XLEN-1], r_data[XLEN-1:1]};
      default: o_next_c = {1'b0, r_data[XLEN-1:1]};
    endcase
  end

  assign o_last_c = (r_cnt == SHAMT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_kind <= SH_SLL;
    end else if (i_load) begin
      r_data <= i_data;
      r_cnt  <= i_shamt;
      r_kind <= i_kind;
    end else if (r_cnt != '0) begin
      r_data <= o_next_c;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/prv32_alu_sequencer.sv
// Sequences one decoded ALU or branch operation through an external ALU:
// IDLE -> ISSUE -> (SHIFT) -> DONE. SERIAL_SHIFT_EN moves shifts to an internal serial shifter.
module prv32_alu_sequencer
  import prv32_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  prv32_alu_sequencer_if.slave bus
);

  state_e          r_state;
  op_ctl_t         r_ctl;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_branch_taken;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_alu_a;
  logic [XLEN-1:0] r_alu_b;
  alufn_e          r_alufn;

  logic            w_accept;
  logic [XLEN-1:0] w_opb;
  alufn_e          w_alufn;
  logic            w_taken;

  // r_in_ready is only ever high in IDLE
  assign w_accept = bus.in_valid && r_in_ready;
  assign w_opb    = (bus.is_imm && !bus.is_branch) ? bus.imm : bus.rs2_val;
  assign w_taken  = branch_cond(r_ctl.funct3, bus.alu_cf, bus.alu_zf, bus.alu_vf, bus.alu_sf);

`ifdef SERIAL_SHIFT_EN
  logic               r_is_shift;
  shift_kind_e        r_shift_kind;
  logic               w_is_shift;
  shift_kind_e        w_shift_kind;
  logic               w_sh_load;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_sh_next;
  logic               w_sh_last;

  // Shifts bypass the ALU; it only sees a PASS of rs1
  assign w_is_shift   = !bus.is_branch && is_shift_op(bus.funct3);
  assign w_shift_kind = (bus.funct3 == F3_SLL) ? SH_SLL : (bus.funct7_5 ? SH_SRA : SH_SRL);
  assign w_alufn      = w_is_shift ? ALUFN_PASS
                                   : decode_alufn(bus.funct3, bus.funct7_5, bus.is_imm, bus.is_branch);
  assign w_shamt      = r_alu_b[SHAMT_W-1:0];
  assign w_sh_load    = (r_state == ST_ISSUE) && r_is_shift;

  prv32_serial_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_sh_load),
    .i_kind   (r_shift_kind),
    .i_data   (r_alu_a),
    .i_shamt  (w_shamt),
    .o_next_c (w_sh_next),
    .o_last_c (w_sh_last)
  );
`else
  assign w_alufn = decode_alufn(bus.funct3, bus.funct7_5, bus.is_imm, bus.is_branch);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_ctl          <= '0;
      r_in_ready     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_branch_taken <= 1'b0;
      r_result       <= '0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alufn        <= ALUFN_ADD;
`ifdef SERIAL_SHIFT_EN
      r_is_shift     <= 1'b0;
      r_shift_kind   <= SH_SLL;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready       <= 1'b0;
            r_ctl.funct3     <= bus.funct3;
            r_ctl.is_branch  <= bus.is_branch;
            r_alu_a          <= bus.rs1_val;
            r_alu_b          <= w_opb;
            r_alufn          <= w_alufn;
`ifdef SERIAL_SHIFT_EN
            r_is_shift       <= w_is_shift;
            r_shift_kind     <= w_shift_kind;
`endif
            r_state          <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_alu_a        <= '0;
          r_alu_b        <= '0;
          r_alufn        <= ALUFN_ADD;
          r_branch_taken <= r_ctl.is_branch && w_taken;
          r_result       <= r_ctl.is_branch ? '0 : bus.alu_r;
          r_out_valid    <= 1'b1;
          r_state        <= ST_DONE;
`ifdef SERIAL_SHIFT_EN
          // shamt==0 completes with the unshifted operand
          if (r_is_shift) begin
            r_result <= r_alu_a;
            if (w_shamt != '0) begin
              r_out_valid <= 1'b0;
              r_state     <= ST_SHIFT;
            end
          end
`endif
        end

        ST_SHIFT: begin
`ifdef SERIAL_SHIFT_EN
          if (w_sh_last) begin
            r_result    <= w_sh_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
`else
          r_state <= ST_IDLE;
`endif
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.result       = r_result;
  assign bus.branch_taken = r_branch_taken;
  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;
  assign bus.alufn        = r_alufn;

endmodule

// File: tb/tb_prv32_alu_sequencer.sv
// Bench for prv32_alu_sequencer: behavioural ALU on the ALU side, directed plus
// random operations checked against an arithmetic reference of the instruction semantics.
module tb_prv32_alu_sequencer;

  localparam int MAX_WAIT = 60;

  logic        clk;
  logic        rst_n;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          prev_cyc = 0;
  int          prev_span = 0;
  bit          have_prev = 1'b0;
  logic [32:0] m_diff;

  prv32_alu_sequencer_if bus ();

  prv32_alu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU driven by the sequencer
  always_comb begin
    m_diff     = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
    bus.alu_cf = m_diff[32];
    bus.alu_zf = (m_diff[31:0] == 32'd0);
    bus.alu_sf = m_diff[31];
    bus.alu_vf = (bus.alu_a[31] != bus.alu_b[31]) && (m_diff[31] != bus.alu_a[31]);
    bus.alu_r  = 32'd0;
    case (bus.alufn)
      4'b0000: bus.alu_r = bus.alu_a + bus.alu_b;
      4'b0001: bus.alu_r = m_diff[31:0];
      4'b0011: bus.alu_r = bus.alu_a;
      4'b0100: bus.alu_r = bus.alu_a | bus.alu_b;
      4'b0101: bus.alu_r = bus.alu_a & bus.alu_b;
      4'b0111: bus.alu_r = bus.alu_a ^ bus.alu_b;
      4'b1000: bus.alu_r = bus.alu_a >> bus.alu_b[4:0];
      4'b1001: bus.alu_r = bus.alu_a << bus.alu_b[4:0];
      4'b1010: bus.alu_r = 32'($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      4'b1101: bus.alu_r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      4'b1111: bus.alu_r = {31'd0, bus.alu_a < bus.alu_b};
      default: bus.alu_r = 32'd0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // {branch_taken, result} from instruction semantics
  function automatic logic [32:0] ref_op(input logic [2:0] f3, input logic f7, input logic imm_sel,
                                         input logic br, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] im);
    logic [31:0] ob;
    int          sh;
    logic        t;
    if (br) begin
      case (f3)
        3'd0:    t = (a == b);
        3'd1:    t = (a != b);
        3'd4:    t = ($signed(a) < $signed(b));
        3'd5:    t = ($signed(a) >= $signed(b));
        3'd6:    t = (a < b);
        3'd7:    t = (a >= b);
        default: t = 1'b0;
      endcase
      return {t, 32'd0};
    end
    ob = imm_sel ? im : b;
    sh = int'(ob % 32);
    case (f3)
      3'd0:    return {1'b0, (!imm_sel && f7) ? a - ob : a + ob};
      3'd1:    return {1'b0, a << sh};
      3'd2:    return {1'b0, 31'd0, $signed(a) < $signed(ob)};
      3'd3:    return {1'b0, 31'd0, a < ob};
      3'd4:    return {1'b0, a ^ ob};
      3'd5:    return {1'b0, f7 ? 32'($signed(a) >>> sh) : a >> sh};
      3'd6:    return {1'b0, a | ob};
      default: return {1'b0, a & ob};
    endcase
  endfunction

  function automatic logic [3:0] ref_alufn(input logic [2:0] f3, input logic f7,
                                           input logic imm_sel, input logic br);
    if (br) return 4'b0001;
    case (f3)
      3'd0:    return (!imm_sel && f7) ? 4'b0001 : 4'b0000;
`ifdef SERIAL_SHIFT_EN
      3'd1:    return 4'b0011;
      3'd5:    return 4'b0011;
`else
      3'd1:    return 4'b1001;
      3'd5:    return f7 ? 4'b1010 : 4'b1000;
`endif
      3'd2:    return 4'b1101;
      3'd3:    return 4'b1111;
      3'd4:    return 4'b0111;
      3'd6:    return 4'b0100;
      default: return 4'b0101;
    endcase
  endfunction

  // Present an op at a negedge and return just after the accepting edge
  task automatic issue_op(input logic [2:0] f3, input logic f7, input logic imm_sel, input logic br,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    int guard;
    guard = 0;
    bus.funct3    = f3;
    bus.funct7_5  = f7;
    bus.is_imm    = imm_sel;
    bus.is_branch = br;
    bus.rs1_val   = a;
    bus.rs2_val   = b;
    bus.imm       = im;
    bus.in_valid  = 1'b1;
    while (bus.in_ready !== 1'b1 && guard < MAX_WAIT) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= MAX_WAIT) check_eq("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    accept_cyc    = cyc;
    bus.in_valid  = 1'b0;
    bus.rs1_val   = $urandom;
    bus.rs2_val   = $urandom;
    bus.imm       = $urandom;
    bus.funct3    = 3'($urandom_range(0, 7));
    bus.funct7_5  = 1'($urandom_range(0, 1));
    bus.is_imm    = 1'($urandom_range(0, 1));
    bus.is_branch = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input logic [2:0] f3, input logic f7, input logic imm_sel, input logic br,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input int hold);
    logic [32:0] exp;
    logic [31:0] ob;
    int          lat;
    int          lat_exp;
    exp     = ref_op(f3, f7, imm_sel, br, a, b, im);
    ob      = (imm_sel && !br) ? im : b;
    lat_exp = 2;
`ifdef SERIAL_SHIFT_EN
    if (!br && (f3 == 3'd1 || f3 == 3'd5)) lat_exp = 2 + int'(ob % 32);
`endif
    bus.out_ready = (hold == 0);
    issue_op(f3, f7, imm_sel, br, a, b, im);
    if (have_prev) check_eq("accept_spacing", 32'(accept_cyc - prev_cyc), 32'(prev_span));
    @(negedge clk);
    check_eq("issue_alu_a", bus.alu_a, a);
    check_eq("issue_alu_b", bus.alu_b, ob);
    check_eq("issue_alufn", 32'(bus.alufn), 32'(ref_alufn(f3, f7, imm_sel, br)));
    check_eq("issue_out_valid", 32'(bus.out_valid), 32'd0);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(lat_exp));
    check_eq("result", bus.result, exp[31:0]);
    check_eq("branch_taken", 32'(bus.branch_taken), 32'(exp[32]));
    check_eq("done_alu_a", bus.alu_a, 32'd0);
    check_eq("done_alufn", 32'(bus.alufn), 32'd0);
    check_eq("done_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_result", bus.result, exp[31:0]);
      check_eq("hold_taken", 32'(bus.branch_taken), 32'(exp[32]));
      check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("post_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("post_in_ready", 32'(bus.in_ready), 32'd1);
    prev_cyc  = accept_cyc;
    prev_span = lat + hold + 1;
    have_prev = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  f3;
    logic        f7;
    logic        imm_sel;
    logic        br;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    int          hold;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.funct3    = 3'd0;
    bus.funct7_5  = 1'b0;
    bus.is_imm    = 1'b0;
    bus.is_branch = 1'b0;
    bus.rs1_val   = 32'd0;
    bus.rs2_val   = 32'd0;
    bus.imm       = 32'd0;
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_result", bus.result, 32'd0);
    check_eq("rst_taken", 32'(bus.branch_taken), 32'd0);
    check_eq("rst_alu_a", bus.alu_a, 32'd0);
    check_eq("rst_alu_b", bus.alu_b, 32'd0);
    check_eq("rst_alufn", 32'(bus.alufn), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("rst_hold_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("release_in_ready", 32'(bus.in_ready), 32'd1);

    run_op(3'd0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 0);
    run_op(3'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 0);
    run_op(3'd4, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    run_op(3'd6, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    run_op(3'd5, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'd4, 0);
    run_op(3'd5, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 0);
    run_op(3'd5, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'd31, 0);
    run_op(3'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'd0, 32'd31, 0);
    run_op(3'd0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'd0, 5);
    run_op(3'd2, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 5);

    // Reset while the op is still in flight must drop it
    bus.out_ready = 1'b0;
    issue_op(3'd5, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'd20);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("midrst_result", bus.result, 32'd0);
    check_eq("midrst_alu_a", bus.alu_a, 32'd0);
    check_eq("midrst_alufn", 32'(bus.alufn), 32'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    have_prev = 1'b0;
    @(negedge clk);
    check_eq("midrst_release_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("midrst_release_out_valid", 32'(bus.out_valid), 32'd0);
    run_op(3'd0, 1'b0, 1'b1, 1'b0, 32'd100, 32'd0, 32'hFFFF_FFFF, 0);

    for (int k = 0; k < 80; k++) begin
      f3      = 3'($urandom_range(0, 7));
      f7      = 1'($urandom_range(0, 1));
      imm_sel = 1'($urandom_range(0, 1));
      br      = ($urandom_range(0, 3) == 0);
      a       = $urandom;
      b       = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = ~a + 32'd1;
      im      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 31));
      hold    = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      run_op(f3, f7, imm_sel, br, a, b, im, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
